// File: rtl/conv2d_engine_arbiter.sv
// conv2d_engine_arbiter: round-robin sequencer sharing one conv2d engine, with done handshake and watchdog
module conv2d_engine_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 eng_start,
    input  logic                 eng_done,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] job_count
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;
    state_t state, state_nx;
    logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_nx, winner, sel_nx;
    logic [CNT_WIDTH-1:0] wdog, wdog_nx, job_count_nx;
    logic [NUM_REQ-1:0]   grant_nx, resp_valid_nx;
    logic                 eng_start_nx, timeout_err_nx, wd_hit;

    assign wd_hit = (TIMEOUT_CYCLES != 0) && (wdog == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // first requester at or after rr_ptr, searching upward with wrap; lowest offset wins
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) winner = SEL_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
    end

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    // next-state logic; done takes priority over the watchdog in RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? RUN : IDLE;
            RUN:     state_nx = (eng_done || wd_hit) ? RELEASE : RUN;
            RELEASE: state_nx = eng_done ? RELEASE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // next values of the registered outputs and bookkeeping state
    always_comb begin
        grant_nx       = grant;
        sel_nx         = sel;
        eng_start_nx   = 1'b0;
        resp_valid_nx  = '0;
        timeout_err_nx = 1'b0;
        job_count_nx   = job_count;
        wdog_nx        = wdog;
        rr_ptr_nx      = rr_ptr;
        case (state)
            IDLE: if (|req) begin
                grant_nx     = NUM_REQ'(1) << winner;
                sel_nx       = winner;
                eng_start_nx = 1'b1;
                wdog_nx      = '0;
            end
            RUN: begin
                wdog_nx        = wdog + CNT_WIDTH'(1);
                eng_start_nx   = !(eng_done || wd_hit);
                resp_valid_nx  = eng_done ? grant : '0;
                job_count_nx   = eng_done ? job_count + CNT_WIDTH'(1) : job_count;
                timeout_err_nx = !eng_done && wd_hit;
            end
            RELEASE: if (!eng_done) begin
                grant_nx  = '0;
                rr_ptr_nx = SEL_WIDTH'((int'(sel) + 1) % NUM_REQ);
            end
            default: ;
        endcase
    end

    // output and bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            sel         <= '0;
            eng_start   <= 1'b0;
            resp_valid  <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            job_count   <= '0;
            wdog        <= '0;
            rr_ptr      <= '0;
        end else begin
            grant       <= grant_nx;
            sel         <= sel_nx;
            eng_start   <= eng_start_nx;
            resp_valid  <= resp_valid_nx;
            timeout_err <= timeout_err_nx;
            busy        <= state_nx != IDLE;
            job_count   <= job_count_nx;
            wdog        <= wdog_nx;
            rr_ptr      <= rr_ptr_nx;
        end
    end
endmodule

// File: tb/tb_conv2d_engine_arbiter.sv
// tb_conv2d_engine_arbiter: directed checks of grant order, handshake, watchdog and reset
module tb_conv2d_engine_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic [3:0]  resp_valid;
    logic        timeout_err;
    logic        busy;
    logic [15:0] job_count;
    int total = 0;
    int fails = 0;

    conv2d_engine_arbiter #(.NUM_REQ(4), .SEL_WIDTH(2), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .sel(sel), .eng_start(eng_start),
        .eng_done(eng_done), .resp_valid(resp_valid), .timeout_err(timeout_err),
        .busy(busy), .job_count(job_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic job(input string tag, input logic [3:0] g, input int idx, input int lat);
        chk({tag, "_grant"}, grant, g);
        chk({tag, "_sel"}, sel, idx);
        chk({tag, "_start"}, eng_start, 1);
        chk({tag, "_busy"}, busy, 1);
        repeat (lat) tick();
        chk({tag, "_start_held"}, eng_start, 1);
        chk({tag, "_no_early_resp"}, resp_valid, 0);
        eng_done = 1'b1;
        tick();
        chk({tag, "_resp"}, resp_valid, g);
        chk({tag, "_start_off"}, eng_start, 0);
        chk({tag, "_grant_release"}, grant, g);
        eng_done = 1'b0;
        tick();
        chk({tag, "_grant_clear"}, grant, 0);
        chk({tag, "_resp_pulse"}, resp_valid, 0);
    endtask

    initial begin
        logic [3:0] order [8];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_sel", sel, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_tout", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", job_count, 0);

        // single requester, done 10 cycles after start, req dropped during RUN
        req = 4'b0001;
        tick();
        req = 4'b0000;
        job("t1", 4'b0001, 0, 9);
        chk("t1_busy_clear", busy, 0);
        chk("t1_count", job_count, 1);

        // fresh reset then all requesters held for 8 jobs
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t2_rst_count", job_count, 0);
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            tick();
            job($sformatf("t2_j%0d", j), order[j], j % 4, 0);
        end
        req = 4'b0000;
        tick();
        chk("t2_idle", grant, 0);
        chk("t2_count", job_count, 8);

        // move rr_ptr to 2, then wrap search picks requester 0 then 1
        req = 4'b0010;
        tick();
        req = 4'b0000;
        job("t3_ptr", 4'b0010, 1, 2);
        req = 4'b0011;
        tick();
        job("t3_wrap", 4'b0001, 0, 1);
        tick();
        req = 4'b0000;
        job("t3_next", 4'b0010, 1, 1);
        chk("t3_count", job_count, 11);

        // watchdog abort 16 cycles after start, then next requester served
        req = 4'b0110;
        tick();
        chk("t4_grant", grant, 4'b0100);
        chk("t4_start", eng_start, 1);
        repeat (15) tick();
        chk("t4_no_early_tout", timeout_err, 0);
        chk("t4_start_held", eng_start, 1);
        tick();
        chk("t4_tout", timeout_err, 1);
        chk("t4_start_off", eng_start, 0);
        chk("t4_no_resp", resp_valid, 0);
        chk("t4_count", job_count, 11);
        req = 4'b0010;
        tick();
        chk("t4_tout_pulse", timeout_err, 0);
        chk("t4_grant_clear", grant, 0);
        tick();
        req = 4'b0000;
        job("t4_next", 4'b0010, 1, 2);
        chk("t4_count_next", job_count, 12);

        // reset three cycles into RUN
        req = 4'b1000;
        tick();
        chk("t5_grant", grant, 4'b1000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t5_start", eng_start, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_busy", busy, 0);
        chk("t5_count", job_count, 0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        req = 4'b0000;
        job("t5_fresh", 4'b0001, 0, 3);

        // done held high for 5 cycles: grant held, single resp pulse, no new grant
        req = 4'b0010;
        tick();
        req = 4'b0101;
        chk("t6_grant", grant, 4'b0010);
        eng_done = 1'b1;
        tick();
        chk("t6_resp", resp_valid, 4'b0010);
        chk("t6_start_off", eng_start, 0);
        repeat (5) begin
            tick();
            chk("t6_grant_held", grant, 4'b0010);
            chk("t6_resp_once", resp_valid, 0);
            chk("t6_start_low", eng_start, 0);
            chk("t6_busy", busy, 1);
        end
        eng_done = 1'b0;
        tick();
        chk("t6_grant_clear", grant, 0);
        tick();
        chk("t6_next_grant", grant, 4'b0100);
        chk("t6_count", job_count, 2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
